// File: rtl/booth_mult_arbiter_pkg.sv
// booth_mult_defs: definitions shared by the Booth multiplier arbiter and its
// round-robin picker.
//   MUL_W / PROD_W : operand and product widths of the shared multiplier
//   ID_W           : width of a requester index (covers up to MAX_REQ lines)
//   ST_*           : sequencer state encodings
package booth_mult_defs;

   localparam int MUL_W   = 8;
   localparam int PROD_W  = 16;
   localparam int ID_W    = 3;
   localparam int MAX_REQ = 8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;

endpackage

// File: rtl/booth_mult_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Scans req starting at rr_ptr, wrapping past NREQ-1 back to 0, and returns
// the first requester found.
//   req    in  NREQ  request levels
//   rr_ptr in  ID_W  highest-priority index for this scan
//   grant  out ID_W  chosen requester (0 when valid is low)
//   valid  out 1     at least one request is set
module rr_pick
   import booth_mult_defs::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] rr_ptr,
   output logic [ID_W-1:0] grant,
   output logic            valid
);

   // Padding to MAX_REQ lets a full ID_W index select a bit without width games.
   logic [MAX_REQ-1:0] req_ext;
   logic [ID_W-1:0]    idx;
   int                 pos;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is
      // inferred on the paths where no request is found.
      req_ext = MAX_REQ'(req);
      grant   = '0;
      valid   = 1'b0;
      idx     = '0;
      pos     = 0;
      for (int i = 0; i < NREQ; i++) begin
         pos = int'(rr_ptr) + i;
         if (pos >= NREQ) pos = pos - NREQ;
         idx = ID_W'(pos);
         if (!valid && req_ext[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: shares one 8x8 signed Booth multiplier among NREQ
// requesters with round-robin fairness and a completion timeout.
//   req, a_in, b_in        requester side: level request + packed operands
//   ack, result, result_id one-cycle completion pulse with product and index
//   busy                   high while an operation is in RUN or RECOVER
//   err                    sticky timeout flag, cleared only by reset
//   mul_start/a/b          multiplier side: level start and held operands
//   mul_done, mul_product  multiplier one-cycle done pulse and product
module booth_mult_arbiter
   import booth_mult_defs::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*MUL_W-1:0]   a_in,
   input  logic [NREQ*MUL_W-1:0]   b_in,
   output logic [NREQ-1:0]         ack,
   output logic [PROD_W-1:0]       result,
   output logic [ID_W-1:0]         result_id,
   output logic                    busy,
   output logic                    err,
   output logic                    mul_start,
   output logic [MUL_W-1:0]        mul_a,
   output logic [MUL_W-1:0]        mul_b,
   input  logic                    mul_done,
   input  logic [PROD_W-1:0]       mul_product
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [1:0]        state_q,     state_d;
   logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [ID_W-1:0]   grant_q,     grant_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [NREQ-1:0]   ack_q,       ack_d;
   logic [PROD_W-1:0] result_q,    result_d;
   logic [ID_W-1:0]   result_id_q, result_id_d;
   logic              err_q,       err_d;
   logic              mul_start_q, mul_start_d;
   logic [MUL_W-1:0]  mul_a_q,     mul_a_d;
   logic [MUL_W-1:0]  mul_b_q,     mul_b_d;

   logic [ID_W-1:0]   pick_idx;
   logic              pick_valid;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .grant  (pick_idx),
      .valid  (pick_valid)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      cnt_d       = cnt_q;
      ack_d       = '0;        // ack is a single-cycle pulse unless set below
      result_d    = result_q;
      result_id_d = result_id_q;
      err_d       = err_q;
      mul_start_d = mul_start_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d     = pick_idx;
               for (int k = 0; k < NREQ; k++) begin
                  if (pick_idx == ID_W'(k)) begin
                     mul_a_d = a_in[k*MUL_W +: MUL_W];
                     mul_b_d = b_in[k*MUL_W +: MUL_W];
                  end
               end
               mul_start_d = 1'b1;
               cnt_d       = '0;
               state_d     = ST_RUN;
            end
         end

         ST_RUN: begin
            // mul_done wins over a timeout landing on the same cycle.
            if (mul_done || (cnt_q == CNT_W'(TIMEOUT))) begin
               result_d    = mul_done ? mul_product : '0;
               err_d       = err_q | ~mul_done;
               result_id_d = grant_q;
               for (int k = 0; k < NREQ; k++) ack_d[k] = (grant_q == ID_W'(k));
               mul_start_d = 1'b0;
               rr_ptr_d    = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);
               state_d     = ST_RECOVER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Dead cycle: the acked requester drops req here, so IDLE never
         // re-grants a stale request.
         ST_RECOVER: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         cnt_q       <= '0;
         ack_q       <= '0;
         result_q    <= '0;
         result_id_q <= '0;
         err_q       <= 1'b0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
      end else begin
         // NOTE: flops use non-blocking assignments so every register samples
         // the pre-edge value of the others.
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         cnt_q       <= cnt_d;
         ack_q       <= ack_d;
         result_q    <= result_d;
         result_id_q <= result_id_d;
         err_q       <= err_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
      end
   end

   assign ack       = ack_q;
   assign result    = result_q;
   assign result_id = result_id_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_RECOVER);
   assign err       = err_q;
   assign mul_start = mul_start_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural 8-step multiplier
// that loads one edge after start rises and pulses done nine edges later.
module tb_booth_mult_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*8-1:0] a_in = '0;
   logic [NREQ*8-1:0] b_in = '0;
   logic [NREQ-1:0]   ack;
   logic [15:0]       result;
   logic [2:0]        result_id;
   logic              busy;
   logic              err;
   logic              mul_start;
   logic [7:0]        mul_a;
   logic [7:0]        mul_b;
   logic              mul_done;
   logic [15:0]       mul_product;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit tie_low = 1'b0;

   booth_mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .a_in        (a_in),
      .b_in        (b_in),
      .ack         (ack),
      .result      (result),
      .result_id   (result_id),
      .busy        (busy),
      .err         (err),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_done    (mul_done),
      .mul_product (mul_product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier model: idle -> busy (load) -> 8 steps -> done pulse -> idle.
   int                 m_state;
   int                 m_cnt;
   logic               m_done;
   logic signed [15:0] m_prod;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         m_cnt   <= 0;
         m_done  <= 1'b0;
         m_prod  <= '0;
      end else begin
         case (m_state)
            0: begin
               m_done <= 1'b0;
               if (mul_start) begin
                  m_state <= 1;
                  m_cnt   <= 0;
                  m_prod  <= $signed(mul_a) * $signed(mul_b);
               end
            end
            1: begin
               if (m_cnt == 8) begin
                  m_state <= 2;
                  m_done  <= !tie_low;
               end else begin
                  m_cnt <= m_cnt + 1;
               end
            end
            default: begin
               m_done  <= 1'b0;
               m_state <= 0;
            end
         endcase
      end
   end

   assign mul_done    = m_done;
   assign mul_product = m_prod;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
      a_in[k*8 +: 8] = a;
      b_in[k*8 +: 8] = b;
   endtask

   // Waits (bounded) for an ack observed at a falling edge; returns the acked
   // index (-1 if none) and the posedge count at which it was seen.
   task automatic wait_ack(input string tag, output int id, output int t);
      id = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (ack != '0) break;
      end
      t = cyc;
      for (int k = 0; k < NREQ; k++) if (ack[k]) id = k;
      check({tag, "_ack_seen"}, 32'(ack != '0), 32'd1);
   endtask

   task automatic serve(input string tag, input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_res, input int exp_lat, input bit exp_err);
      int id, t, t0;
      set_ops(k, a, b);
      req[k] = 1'b1;
      t0 = cyc + 1;
      wait_ack(tag, id, t);
      check({tag, "_id"},        32'(id),        32'(k));
      check({tag, "_ack"},       32'(ack),       32'(1 << k));
      check({tag, "_latency"},   32'(t - t0),    32'(exp_lat));
      check({tag, "_result"},    32'(result),    32'(exp_res));
      check({tag, "_result_id"}, 32'(result_id), 32'(k));
      check({tag, "_err"},       32'(err),       32'(exp_err));
      req[k] = 1'b0;
      @(negedge clk);
      check({tag, "_ack_fall"},  32'(ack),       32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [15:0] rr_exp [4];
   int id, t, prev_t;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ack",       32'(ack),       32'd0);
      check("rst_result",    32'(result),    32'd0);
      check("rst_result_id", 32'(result_id), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_err",       32'(err),       32'd0);
      check("rst_mul_start", 32'(mul_start), 32'd0);
      check("rst_mul_a",     32'(mul_a),     32'd0);
      check("rst_mul_b",     32'(mul_b),     32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request with a look at the multiplier side during RUN
      set_ops(0, 8'd3, 8'd5);
      req[0] = 1'b1;
      @(negedge clk);
      check("run_busy",      32'(busy),      32'd1);
      check("run_mul_start", 32'(mul_start), 32'd1);
      check("run_mul_a",     32'(mul_a),     32'd3);
      check("run_mul_b",     32'(mul_b),     32'd5);
      check("run_no_ack",    32'(ack),       32'd0);
      req[0] = 1'b0;   // dropped early: the op must still complete
      wait_ack("early_drop", id, t);
      check("early_drop_id",     32'(id),     32'd0);
      check("early_drop_result", 32'(result), 32'd15);
      @(negedge clk);
      check("early_drop_mul_start", 32'(mul_start), 32'd0);
      check("early_drop_idle_busy", 32'(busy),      32'd0);

      // Single request, exact latency (rr_ptr now 1, only line 0 asks)
      serve("single", 0, 8'd3,   8'd5,   16'h000F, 11, 1'b0);
      // Signed corner cases, walking rr_ptr 1 -> 2 -> 3 -> 0
      serve("neg_neg", 1, 8'h80, 8'h80, 16'h4000, 11, 1'b0);
      serve("neg_pos", 2, 8'hF9, 8'h09, 16'hFFC1, 11, 1'b0);
      serve("max_m1",  3, 8'h7F, 8'hFF, 16'hFF81, 11, 1'b0);
      serve("ptr3",    2, 8'd2,  8'd2,  16'h0004, 11, 1'b0);

      // Fairness after wrap: rr_ptr=3 with req=1001 serves 3 before 0
      set_ops(3, 8'd10, 8'hFD);
      set_ops(0, 8'hFB, 8'hFB);
      req = 4'b1001;
      wait_ack("wrap_first", id, t);
      check("wrap_first_id",     32'(id),     32'd3);
      check("wrap_first_result", 32'(result), 32'h0000FFE2);
      req[3] = 1'b0;
      prev_t = t;
      wait_ack("wrap_second", id, t);
      check("wrap_second_id",     32'(id),         32'd0);
      check("wrap_second_result", 32'(result),     32'h00000019);
      check("wrap_spacing",       32'(t - prev_t), 32'd13);
      req[0] = 1'b0;
      @(negedge clk);

      // Round robin with all four lines requesting, starting from rr_ptr=0
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_ops(0, 8'd1,   8'd1);
      set_ops(1, 8'hFE,  8'd3);
      set_ops(2, 8'd100, 8'd100);
      set_ops(3, 8'h9C,  8'd50);
      rr_exp = '{16'h0001, 16'hFFFA, 16'h2710, 16'hEC78};
      req = 4'hF;
      prev_t = 0;
      for (int s = 0; s < 5; s++) begin
         wait_ack("rr", id, t);
         check("rr_order",  32'(id),     32'(s % 4));
         check("rr_result", 32'(result), 32'(rr_exp[s % 4]));
         if (s > 0) check("rr_spacing", 32'(t - prev_t), 32'd13);
         prev_t = t;
         req[s % 4] = 1'b0;
         @(negedge clk);
         if (s < 4) req[s % 4] = 1'b1;
      end
      req = '0;
      @(negedge clk);

      // Timeout: multiplier never signals done (rr_ptr is 1 here)
      tie_low = 1'b1;
      serve("timeout", 1, 8'd4, 8'd4, 16'h0000, TIMEOUT + 1, 1'b1);
      repeat (3) @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
      rst_n = 1'b0;
      #1;
      check("err_cleared", 32'(err), 32'd0);
      tie_low = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Reset at cycle 5 of RUN, then the same request is re-served
      set_ops(2, 8'hF9, 8'h09);
      req[2] = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("midrun_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrun_ack",       32'(ack),       32'd0);
      check("midrun_busy",      32'(busy),      32'd0);
      check("midrun_mul_start", 32'(mul_start), 32'd0);
      check("midrun_mul_a",     32'(mul_a),     32'd0);
      check("midrun_mul_b",     32'(mul_b),     32'd0);
      check("midrun_result",    32'(result),    32'd0);
      @(negedge clk);
      check("midrun_held_ack",  32'(ack),       32'd0);
      rst_n = 1'b1;
      serve("reserve", 2, 8'hF9, 8'h09, 16'hFFC1, 11, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin arbiter and sequencer that shares one 8×8 signed Booth multiplier among NREQ requesters. It grants one requester at a time and drives the multiplier's level-held start. It returns the 16-bit product with a one-cycle ack and guards the operation with a completion timeout. The block sits between client datapaths and the single multiplier instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 15, max cycles in RUN before abort (must be ≥ 11)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held with operands until ack
- a_in  in  NREQ*8  packed multiplicands, requester k at [8k+7:8k]
- b_in  in  NREQ*8  packed multipliers, same packing
- ack  out  NREQ  one-hot, one-cycle completion pulse
- result  out  16  signed product, valid while any ack bit is high
- result_id  out  3  index of the acked requester
- busy  out  1  high in RUN and RECOVER
- err  out  1  sticky timeout flag, cleared only by reset
- mul_start  out  1  multiplier start level
- mul_a, mul_b  out  8  multiplier operands
- mul_done  in  1  multiplier one-cycle done pulse
- mul_product  in  16  multiplier product, valid while mul_done is high

## Operation
- States: IDLE, RUN, RECOVER.
- IDLE:
  - If req is nonzero, pick the first set bit at or after rr_ptr, wrapping.
  - Register grant and mul_a/mul_b from that requester's slice, set mul_start=1, clear the timeout counter, go to RUN.
  - Otherwise hold.
- RUN:
  - mul_start, mul_a and mul_b are held constant; the counter increments each cycle.
  - If mul_done is sampled high: result<=mul_product, result_id<=grant, ack[grant]<=1, mul_start<=0, rr_ptr<=grant+1 (mod NREQ), go to RECOVER.
  - mul_start is still high at the edge that samples mul_done, so the multiplier returns to its idle step.
- Timeout: if the counter reaches TIMEOUT before mul_done, do the same actions with result<=0 and err<=1.
- RECOVER: ack, result and result_id remain valid this single cycle. At the next edge ack<=0 and the state goes to IDLE.
- Requester rule: req must drop at the edge that ends its ack cycle. Because RECOVER is a dead cycle, IDLE never sees a stale req.
- A requester that drops req before its ack still receives its ack; the operation is never cancelled.
- req changes on non-granted lines during RUN or RECOVER are allowed and have no effect until IDLE.
- Signed arithmetic: result is the two's-complement 16-bit product of signed a and b.

## Timing
- Reset values: state=IDLE, rr_ptr=0, ack=0, result=0, result_id=0, busy=0, err=0, mul_start=0, mul_a=0, mul_b=0.
- Let E0 be the IDLE edge that samples req. The multiplier's 8-step cycle produces this sequence:
  - E1: multiplier loads.
  - E10: mul_done rises.
  - E11: ack rises.
  - E12: ack falls; state is IDLE.
  - E13: next grant.
- Request-to-ack latency is 11 cycles; back-to-back service is one product per 13 cycles.
- Reset asserted mid-operation forces all outputs to reset values immediately; no ack is issued for the aborted request.
- With all requesters continuously requesting, grants rotate 0,1,…,NREQ-1,0 with no starvation.

## Structure
- Shared package/include `booth_mult_defs`:
  - MUL_W=8 and PROD_W=16.
  - State encodings ST_IDLE, ST_RUN, ST_RECOVER.
  - Result-id width constant.
- One sub-module, `rr_pick`: combinational masked-priority picker taking req and rr_ptr and returning a grant index and a valid bit.

## Test plan
- Single request: req=0001, a0=3, b0=5 → ack[0] pulses 11 cycles after the sampling edge, result=15, result_id=0, err=0.
- Signed values: a=−128, b=−128 → 16384. a=−7, b=9 → −63 (0xFFC1). a=127, b=−1 → −127.
- Round-robin: req=1111 held with distinct operands, each line dropped after its ack and reasserted → ack order 0,1,2,3,0, each result correct, 13-cycle spacing.
- Fairness after wrap: rr_ptr=3 with req=1001 → requester 3 is served before 0.
- Timeout: mul_done tied low → ack at TIMEOUT+1 cycles after grant with result=0, err stays 1 until rst_n low.
- Reset mid-RUN: rst_n low at cycle 5 of RUN → all outputs at reset values immediately; after release the same req is re-served with the correct result.
